// File: rtl/sd_dac_streamer.sv
// sd_dac_streamer: accepts signed PCM samples over valid/ready, holds each
// sample for OSR clocks and drives a 2nd-order sigma-delta modulator that
// emits a 1-bit density stream. Deasserting enable flushes the modulator on
// a zero input for OSR clocks before returning to IDLE.
// Optional build macro SD_DAC_DITHER_EN adds a 16-bit Galois LFSR whose LSB
// injects a +1/-1 term into the first integrator to break idle tones.
module sd_dac_streamer #(
    parameter int DATA_W = 16,
    parameter int OSR    = 64,
    parameter int ACC_W  = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     bit_out,
    output logic                     bit_valid,
    output logic                     underrun,
    output logic                     busy
);

    localparam int CNT_W = $clog2(OSR);
    // Two guard bits cover int2 + int1 - 2*fb before saturation.
    localparam int SUM_W = ACC_W + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    localparam logic signed [SUM_W-1:0] FS      = SUM_W'(longint'(1) << (DATA_W - 1));
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((longint'(1) << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);

    localparam logic signed [DATA_W-1:0] DATA_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_CLAMP = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN, FLUSH} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  hold;
    logic signed [ACC_W-1:0]   int1;
    logic signed [ACC_W-1:0]   int2;

    logic signed [SUM_W-1:0]   x_ext;
    logic signed [SUM_W-1:0]   fb_ext;
    logic signed [SUM_W-1:0]   int1_ext;
    logic signed [SUM_W-1:0]   int2_ext;
    logic signed [SUM_W-1:0]   dith;
    logic signed [SUM_W-1:0]   sum1;
    logic signed [SUM_W-1:0]   sum2;
    logic signed [ACC_W-1:0]   int1_nxt;
    logic signed [ACC_W-1:0]   int2_nxt;
    logic                      bit_nxt;

`ifdef SD_DAC_DITHER_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    logic [15:0] lfsr;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction
`endif

    // Integrators clamp symmetrically so they can never wrap.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > ACC_MAX)
            return ACC_MAX[ACC_W-1:0];
        else if (v < ACC_MIN)
            return ACC_MIN[ACC_W-1:0];
        else
            return v[ACC_W-1:0];
    endfunction

    // The most negative code has no positive mirror; fold it one step inward.
    function automatic logic signed [DATA_W-1:0] clamp_in(input logic signed [DATA_W-1:0] d);
        return (d == DATA_MIN) ? DATA_CLAMP : d;
    endfunction

    assign in_ready  = enable && ((state == WAIT_FIRST) ||
                                  ((state == RUN) && (cnt == CNT_LAST)));
    assign bit_valid = (state == RUN) || (state == FLUSH);
    assign busy      = (state != IDLE);

    // Next modulator state from the held sample and the previous output bit.
    always_comb begin
        x_ext    = SUM_W'(hold);
        fb_ext   = bit_out ? FS : -FS;
        int1_ext = SUM_W'(int1);
        int2_ext = SUM_W'(int2);
`ifdef SD_DAC_DITHER_EN
        dith     = lfsr[0] ? ONE : -ONE;
`else
        dith     = '0;
`endif
        sum1     = int1_ext + x_ext - fb_ext + dith;
        sum2     = int2_ext + int1_ext - (fb_ext <<< 1);
        int1_nxt = sat_acc(sum1);
        int2_nxt = sat_acc(sum2);
        bit_nxt  = ~int2_nxt[ACC_W-1];
    end

    // Control FSM with sample hold, slot counter and modulator registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hold     <= '0;
            int1     <= '0;
            int2     <= '0;
            bit_out  <= 1'b0;
            underrun <= 1'b0;
`ifdef SD_DAC_DITHER_EN
            lfsr     <= LFSR_SEED;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bit_out <= 1'b0;
                    if (enable) begin
                        state    <= WAIT_FIRST;
                        underrun <= 1'b0;
`ifdef SD_DAC_DITHER_EN
                        lfsr     <= LFSR_SEED;
`endif
                    end
                end
                WAIT_FIRST: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (in_valid) begin
                        hold  <= clamp_in(in_data);
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    int1    <= int1_nxt;
                    int2    <= int2_nxt;
                    bit_out <= bit_nxt;
`ifdef SD_DAC_DITHER_EN
                    lfsr    <= lfsr_step(lfsr);
`endif
                    if (!enable) begin
                        state <= FLUSH;
                        hold  <= '0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            if (in_valid)
                                hold <= clamp_in(in_data);
                            else
                                underrun <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
`ifdef SD_DAC_DITHER_EN
                    lfsr <= lfsr_step(lfsr);
`endif
                    if (cnt == CNT_LAST) begin
                        int1    <= '0;
                        int2    <= '0;
                        bit_out <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        int1    <= int1_nxt;
                        int2    <= int2_nxt;
                        bit_out <= bit_nxt;
                        cnt     <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dac_streamer.sv
// Bench for sd_dac_streamer (DATA_W=16, OSR=64, ACC_W=22). Stimulus pushes
// expected bit-stream windows (exact bits or ones-count ranges) into a queue;
// a monitor pops them as the DUT presents valid bits.
module tb_sd_dac_streamer;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               bit_out;
    logic               bit_valid;
    logic               underrun;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    nbits;
        int    lo;
        int    hi;
    } win_t;

    win_t exp_q[$];
    int   win_n    = 0;
    int   win_ones = 0;

    sd_dac_streamer #(.DATA_W(16), .OSR(64), .ACC_W(22)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .underrun (underrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Monitor: accumulate valid bits into the window at the head of the queue.
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            win_n    = 0;
            win_ones = 0;
        end else if (reset && bit_valid) begin
            win_ones += int'(bit_out);
            win_n++;
            if (win_n == exp_q[0].nbits) begin
                checks++;
                if (win_ones < exp_q[0].lo || win_ones > exp_q[0].hi) begin
                    errors++;
                    $display("FAIL %s: ones=%0d over %0d bits, required %0d..%0d",
                             exp_q[0].tag, win_ones, win_n, exp_q[0].lo, exp_q[0].hi);
                end
                void'(exp_q.pop_front());
                win_n    = 0;
                win_ones = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_win(input string tag, input int nbits, input int lo, input int hi);
        win_t w;
        w.tag   = tag;
        w.nbits = nbits;
        w.lo    = lo;
        w.hi    = hi;
        exp_q.push_back(w);
    endtask

    // Hand-derived start of the x=0 stream from cleared integrators:
    // reset bit 0, then 1,1,0,1,0,0,1,1 (period 1100 thereafter).
    task automatic push_zero_start(input string pfx);
        int seq[9] = '{0, 1, 1, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 9; i++)
            push_win($sformatf("%s_bit%0d", pfx, i), 1, seq[i], seq[i]);
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL window_timeout: %0d windows pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Returns on a negedge where in_ready is high in RUN, i.e. cnt == 63.
    task automatic wait_slot();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL slot_timeout: in_ready=0, required 1");
        end
    endtask

    // Skip one sample slot; returns just after the edge that closed the slot.
    task automatic drop_slot(input bit with_win);
        wait_slot();
        repeat (64) @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (with_win) begin
            in_data = 16'shC000;
            push_win("hold_repeat", 64, 44, 52);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        if (with_win) in_data = 16'sh4000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int  fl;
        int  rdy;
        bit  done;

        reset    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_bit_out",   int'(bit_out),   0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_in_ready",  int'(in_ready),  0);
        chk("rst_underrun",  int'(underrun),  0);
        reset = 1'b1;

        // x = 0 stream: exact opening bits, then 50 % density
        @(posedge clk);
        #1;
        in_data  = '0;
        in_valid = 1'b1;
`ifndef SD_DAC_DITHER_EN
        push_zero_start("x0");
`endif
        push_win("x0_density", 1024, 508, 516);
`ifdef SD_DAC_DITHER_EN
        push_win("dither_x0_density", 4096, 2028, 2068);
`endif
        @(negedge clk);
        chk("idle_ready_before_enable", int'(in_ready), 0);
        enable = 1'b1;
        wait_empty(6000);

        // Constant +0.5 FS: 75 % density
        @(posedge clk);
        #1;
        in_data = 16'sh4000;
        repeat (256) @(posedge clk);
        #1;
        push_win("x4000_density", 4096, 3052, 3092);
        wait_empty(5000);
        @(negedge clk);
        chk("no_underrun", int'(underrun), 0);

        // Missed slot: underrun sets and sticks, hold keeps +0.5 FS
        drop_slot(1'b1);
        @(negedge clk);
        chk("underrun_set", int'(underrun), 1);
        wait_empty(400);
        repeat (128) @(negedge clk);
        chk("underrun_sticky", int'(underrun), 1);

        // Most negative code is clamped: almost no ones
        @(posedge clk);
        #1;
        in_data = 16'sh8000;
        repeat (1024) @(posedge clk);
        #1;
        push_win("clamp_density", 4096, 0, 4);
        wait_empty(5000);

        // Deassert enable at cnt = 20, re-assert mid-flush (ignored)
        wait_slot();
        repeat (21) @(posedge clk);
        #1;
        enable  = 1'b0;
        in_data = '0;
        @(negedge clk);
        chk("ready_drop", int'(in_ready), 0);
        fl   = 0;
        rdy  = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (bit_valid) begin
                fl++;
                if (in_ready) rdy++;
                if (fl == 30) enable = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        chk("flush_len",          fl,              64);
        chk("flush_ready",        rdy,             0);
        chk("idle_busy",          int'(busy),      0);
        chk("idle_bit_out",       int'(bit_out),   0);
        chk("idle_in_ready",      int'(in_ready),  0);
        chk("idle_underrun_held", int'(underrun),  1);
`ifndef SD_DAC_DITHER_EN
        push_zero_start("restart");
`endif
        @(negedge clk);
        chk("wait_busy",        int'(busy),     1);
        chk("underrun_cleared", int'(underrun), 0);
        chk("wait_in_ready",    int'(in_ready), 1);
        wait_empty(200);

        // Async reset in RUN at cnt = 37
        drop_slot(1'b0);
        chk("underrun_before_rst", int'(underrun), 1);
        repeat (37) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_bit_valid", int'(bit_valid), 0);
        chk("mid_rst_bit_out",   int'(bit_out),   0);
        chk("mid_rst_busy",      int'(busy),      0);
        chk("mid_rst_in_ready",  int'(in_ready),  0);
        chk("mid_rst_underrun",  int'(underrun),  0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 0);
        chk("post_rst_busy",     int'(busy),     0);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_in_ready", int'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
